// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Per-bit two-flop synchroniser and stability-counter debouncer
//               with press/release strobes. Define KEY_DEBOUNCE_IRQ_EN to
//               build the sticky capture flags and irq output.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    // "release" is a reserved word, hence the suffix
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] capture,
    input  logic [WIDTH-1:0] capture_clr,
    output logic             irq
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [WIDTH-1:0]   w_norm;
    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_level;
    logic [WIDTH-1:0]   r_press;
    logic [WIDTH-1:0]   r_release;
    logic [c_CNT_W-1:0] r_cnt [WIDTH];

    // Normalise so that 1 always means pressed/asserted downstream
    assign w_norm = ACTIVE_LOW ? ~raw : raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_norm;
            r_sync2 <= r_sync1;
            for (int i = 0; i < WIDTH; i++) begin
                r_press[i]   <= 1'b0;
                r_release[i] <= 1'b0;
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_CNT_MAX) begin
                    r_level[i]   <= r_sync2[i];
                    r_cnt[i]     <= '0;
                    r_press[i]   <= r_sync2[i];
                    r_release[i] <= ~r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
                end
            end
        end
    end

    assign level         = r_level;
    assign press         = r_press;
    assign release_pulse = r_release;

`ifdef KEY_DEBOUNCE_IRQ_EN
    logic [WIDTH-1:0] r_capture;
    logic             r_irq;

    // A press arriving with a clear on the same bit keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_capture <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_capture <= r_press | (r_capture & ~capture_clr);
            r_irq     <= |r_capture;
        end
    end

    assign capture = r_capture;
    assign irq     = r_irq;
`else
    logic w_unused_clr;

    assign w_unused_clr = ^capture_clr;
    assign capture      = '0;
    assign irq          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce
// Description : Directed, table-driven bench for key_debounce
//               (WIDTH=4, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] release_pulse;
    logic [3:0] capture;
    logic [3:0] capture_clr;
    logic       irq;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      name;
        logic [3:0] raw;
        logic [3:0] clr;
        int         cycles;
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] cap;
        logic       irq;
    } vec_t;

    vec_t vecs[$];

    key_debounce #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(8),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw          (raw),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .capture      (capture),
        .capture_clr  (capture_clr),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic add(input string name, input logic [3:0] r, input logic [3:0] clr,
                       input int cycles, input logic [3:0] lv, input logic [3:0] pr,
                       input logic [3:0] rl, input logic [3:0] cp, input logic iq);
        vec_t v;
        v.name = name; v.raw = r; v.clr = clr; v.cycles = cycles;
        v.level = lv; v.press = pr; v.rel = rl; v.cap = cp; v.irq = iq;
        vecs.push_back(v);
    endtask

    // Capture/irq expectations in the table are for the IRQ build; the
    // plain build must hold them at zero.
    function automatic logic [3:0] exp_cap(input logic [3:0] c);
`ifdef KEY_DEBOUNCE_IRQ_EN
        return c;
`else
        return 4'b0000;
`endif
    endfunction

    function automatic logic exp_irq(input logic i);
`ifdef KEY_DEBOUNCE_IRQ_EN
        return i;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        // Each record: outputs must match on every cycle of the segment.
        add("idle",        4'b1111, 4'b0000, 12, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Clean press on bit 0
        add("s1_wait",     4'b1110, 4'b0000,  9, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add("s1_press",    4'b1110, 4'b0000,  1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        add("s1_cap",      4'b1110, 4'b0000,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0);
        add("s1_irq",      4'b1110, 4'b0000,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        // Bounce on bit 1 never settles long enough
        for (int k = 0; k < 4; k++) begin
            add("s2_low",  4'b1100, 4'b0000,  5, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
            add("s2_high", 4'b1110, 4'b0000,  2, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        end
        add("s2_settle",   4'b1110, 4'b0000, 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        // Release bit 0, then clear its capture flag
        add("s3_wait",     4'b1111, 4'b0000,  9, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        add("s3_release",  4'b1111, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b1);
        add("s3_after",    4'b1111, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        add("s3_clr",      4'b1111, 4'b0001,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add("s3_irq_drop", 4'b1111, 4'b0000,  2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        // All four bits at once; clear collides with the press strobes
        add("s4_wait",     4'b0000, 4'b0000,  9, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add("s4_press",    4'b0000, 4'b0000,  1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0);
        add("s4_setwins",  4'b0000, 4'b1111,  1, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b0);
        add("s4_irq",      4'b0000, 4'b0000,  1, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b1);
        add("s4_rwait",    4'b1111, 4'b0000,  9, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b1);
        add("s4_release",  4'b1111, 4'b0000,  1, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b1);
        add("s4_clr",      4'b1111, 4'b1111,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add("s4_quiet",    4'b1111, 4'b0000,  2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Reset with every key released
        reset       = 1'b1;
        raw         = 4'b1111;
        capture_clr = 4'b0000;
        tick(); tick(); tick();
        check("rst_level",   32'(level),         32'h0);
        check("rst_press",   32'(press),         32'h0);
        check("rst_release", 32'(release_pulse), 32'h0);
        check("rst_capture", 32'(capture),       32'h0);
        check("rst_irq",     32'(irq),           32'h0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            raw         = vecs[i].raw;
            capture_clr = vecs[i].clr;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                tick();
                check({vecs[i].name, "_level"},   32'(level),         32'(vecs[i].level));
                check({vecs[i].name, "_press"},   32'(press),         32'(vecs[i].press));
                check({vecs[i].name, "_release"}, 32'(release_pulse), 32'(vecs[i].rel));
                check({vecs[i].name, "_capture"}, 32'(capture),       32'(exp_cap(vecs[i].cap)));
                check({vecs[i].name, "_irq"},     32'(irq),           32'(exp_irq(vecs[i].irq)));
            end
        end
        capture_clr = 4'b0000;

        // Reset in the middle of a count on bit 2, key held through it
        raw = 4'b1011;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("s5_pre_press", 32'({level, press}), 32'h0);
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("s5_in_reset", 32'({level, press, release_pulse}), 32'h0);
        end
        reset = 1'b0;
        for (int c = 0; c < 9; c++) begin
            tick();
            check("s5_post_rst", 32'({level, press, release_pulse}), 32'h0);
        end
        tick();
        check("s5_press", 32'(press), 32'h4);
        check("s5_level", 32'(level), 32'h4);
        tick();
        check("s5_strobe_end", 32'(press),   32'h0);
        check("s5_capture",    32'(capture), 32'(exp_cap(4'b0100)));
        tick();
        check("s5_irq",        32'(irq),     32'(exp_irq(1'b1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
